// File: rtl/neuron_core_pkg.sv
// Shared types and constants for the neuron core datapath.
package neuron_core_pkg;

  localparam int unsigned NEURON_IDX_W = 8;
  localparam int unsigned SPIKE_PKT_W  = NEURON_IDX_W + 1;
  localparam int unsigned EOF_BIT      = NEURON_IDX_W;

  typedef enum logic [1:0] {
    COLLECT,
    EOF_PEND,
    DRAIN
  } enc_state_e;

endpackage

// File: rtl/spike_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is presented combinationally.
module spike_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
  assign empty_o = wptr_q == rptr_q;
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= data_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_packet_encoder.sv
// Queues spiking neuron indices and emits them, then an EOF packet, to the router.
// Optional SPIKE_COUNT_EN adds a per-frame spike counter output.
module spike_packet_encoder
  import neuron_core_pkg::*;
#(
  parameter int unsigned IDX_W = NEURON_IDX_W,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PKT_W = IDX_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             neuron_valid_i,
  input  logic [IDX_W-1:0] neuron_idx_i,
  input  logic             spike_i,
  input  logic             frame_done_i,
  output logic             busy_o,
  output logic             pkt_valid_o,
  output logic [PKT_W-1:0] pkt_data_o,
  input  logic             pkt_ready_i,
  output logic             frame_end_o,
`ifdef SPIKE_COUNT_EN
  output logic [IDX_W:0]   spike_count_o,
`endif
  output logic             overflow_o
);

  enc_state_e       state_q, state_d;
  logic [IDX_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;
  logic             fifo_push, fifo_full, fifo_empty, pop;
  logic [PKT_W-1:0] fifo_wdata;

  spike_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (pop),
    .data_o  (pkt_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pkt_valid_o = !fifo_empty;
  assign pop         = pkt_valid_o && pkt_ready_i;
  assign overflow_o  = overflow_q;

  always_comb begin
    state_d     = state_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;
    fifo_push   = 1'b0;
    fifo_wdata  = {1'b0, neuron_idx_i};
    busy_o      = 1'b1;
    frame_end_o = 1'b0;
    unique case (state_q)
      COLLECT: begin
        busy_o = 1'b0;
        if (neuron_valid_i && spike_i) begin
          fifo_push = 1'b1;
          if (fifo_full && !pop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
          end
        end
        if (frame_done_i) state_d = EOF_PEND;
      end
      EOF_PEND: begin
        if (!fifo_full || pop) begin
          fifo_push  = 1'b1;
          fifo_wdata = {1'b1, drop_cnt_q};
          drop_cnt_d = '0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        // EOF is always the last entry, so its departure empties the FIFO.
        if (pop && pkt_data_o[IDX_W]) begin
          frame_end_o = 1'b1;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= COLLECT;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef SPIKE_COUNT_EN
  logic [IDX_W:0] spike_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spike_cnt_q <= '0;
    end else if (frame_end_o) begin
      spike_cnt_q <= '0;
    end else if (state_q == COLLECT && neuron_valid_i && spike_i) begin
      spike_cnt_q <= spike_cnt_q + 1'b1;
    end
  end

  assign spike_count_o = spike_cnt_q;
`endif

endmodule
